// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment pattern type, bit positions and hex glyph table.
package seg_pkg;
    typedef logic [7:0] seg_t;
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;
    localparam seg_t SEG_BLANK = 8'h00;
    localparam seg_t HEX_TABLE [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };
endpackage

// File: rtl/seg_decode.sv
// seg_decode: hex nibble to A..G pattern, decimal point always clear.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       pattern
);
    assign pattern = HEX_TABLE[nibble] & ~(seg_t'(1) << SEG_DP);
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered, time-multiplexed seven-segment scanner.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYCLES    = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done,
    output logic                    pending
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] stg_value, shd_value;
    logic [NUM_DIGITS-1:0]   stg_dp, shd_dp, stg_en, shd_en;
    logic [NUM_DIGITS-1:0]   onehot, an_next, an_q;
    logic                    slot_end, wrap, dead, dp_bit, en_bit, lead;
    logic [3:0]              nib;
    seg_t                    dec, seg_next, seg_q;

    assign slot_end   = presc == PW'(CLK_DIV - 1);
    assign wrap       = slot_end && idx == IW'(NUM_DIGITS - 1);
    assign frame_done = wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= slot_end ? '0 : presc + 1'b1;
            if (slot_end)
                idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end

    // Shadow only moves at the frame wrap; a load on that very cycle bypasses staging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_value <= '0;
            stg_dp    <= '0;
            stg_en    <= '0;
            shd_value <= '0;
            shd_dp    <= '0;
            shd_en    <= '0;
            pending   <= 1'b0;
        end else begin
            if (load)
                {stg_value, stg_dp, stg_en} <= {value, dp_mask, digit_en};
            if (wrap && (pending || load))
                {shd_value, shd_dp, shd_en} <= load ? {value, dp_mask, digit_en}
                                                    : {stg_value, stg_dp, stg_en};
            pending <= wrap ? 1'b0 : (pending || load);
        end
    end

    seg_decode u_decode (
        .nibble  (nib),
        .pattern (dec)
    );

    always_comb begin
        onehot   = NUM_DIGITS'(1) << idx;
        nib      = 4'(shd_value >> {idx, 2'b00});
        dp_bit   = |(shd_dp & onehot);
        en_bit   = |(shd_en & onehot);
        lead     = BLANK_LEADING != 0 && idx != '0 && (shd_value >> {idx, 2'b00}) == '0;
        dead     = int'(presc) < DEAD_CYCLES;
        seg_next = !en_bit ? SEG_BLANK
                 : (lead ? SEG_BLANK : dec) | (seg_t'(dp_bit) << SEG_DP);
        an_next  = (dead || !en_bit) ? '0 : onehot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            an_q  <= '0;
        end else begin
            seg_q <= seg_next;
            an_q  <= an_next;
        end
    end

    assign segments = SEG_ACTIVE_LOW != 0 ? ~seg_q : seg_q;
    assign anodes   = AN_ACTIVE_LOW != 0 ? ~an_q : an_q;
endmodule
